// File: rtl/gate_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module  : gate_seq_pkg
// Brief   : Shared types and constants for the gate stimulus sequencer.
// Revision: 1.0 - initial release
// ============================================================================
package gate_seq_pkg;

    localparam int NUM_VECTORS = 8;
    localparam int VEC_W       = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage : gate_seq_pkg
`default_nettype wire

// File: rtl/sw_debouncer.sv
`default_nettype none
// ============================================================================
// Module  : sw_debouncer
// Brief   : One switch bit: 2-flop synchronizer and stable-count filter.
// Revision: 1.0 - initial release
// ============================================================================
module sw_debouncer #(
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic commit_pulse
);

    localparam int c_CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic               r_s1_q;
    logic               r_s2_q;
    logic               r_dout_q;
    logic               w_dout_d;
    logic [c_CNT_W-1:0] r_cnt_q;
    logic [c_CNT_W-1:0] w_cnt_d;
    logic               w_differ;

    // commit_pulse is combinational so the top can load the new value on the
    // same edge the committed bit flips.
    always_comb begin
        w_differ     = (r_s2_q != r_dout_q);
        commit_pulse = w_differ && (r_cnt_q == c_CNT_LAST);
        w_dout_d     = r_dout_q;
        w_cnt_d      = '0;
        if (commit_pulse) begin
            w_dout_d = r_s2_q;
        end else if (w_differ) begin
            w_cnt_d = r_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_q   <= 1'b0;
            r_s2_q   <= 1'b0;
            r_dout_q <= 1'b0;
            r_cnt_q  <= '0;
        end else begin
            r_s1_q   <= din;
            r_s2_q   <= r_s1_q;
            r_dout_q <= w_dout_d;
            r_cnt_q  <= w_cnt_d;
        end
    end

    assign dout = r_dout_q;

endmodule : sw_debouncer
`default_nettype wire

// File: rtl/gate_stimulus_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : gate_stimulus_sequencer
// Brief   : Drives gate inputs a/b/c from debounced switches or an auto sweep.
// Revision: 1.0 - initial release
// ============================================================================
module gate_stimulus_sequencer
    import gate_seq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int DWELL_CYCLES    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic             start,
    input  logic [VEC_W-1:0] sw,
    output logic             a,
    output logic             b,
    output logic             c,
    output logic             vec_valid,
    output logic [VEC_W-1:0] vec_idx,
    output logic             busy,
    output logic             done
);

    localparam int c_DW_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [c_DW_W-1:0] c_DWELL_LAST = c_DW_W'(DWELL_CYCLES - 1);
    localparam logic [VEC_W-1:0]  c_VEC_LAST   = VEC_W'(NUM_VECTORS - 1);

    logic [VEC_W-1:0] w_deb_val;
    logic [VEC_W-1:0] w_commit;

    for (genvar gi = 0; gi < VEC_W; gi++) begin : g_deb
        sw_debouncer #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_deb (
            .clk          (clk),
            .rst          (rst),
            .din          (sw[gi]),
            .dout         (w_deb_val[gi]),
            .commit_pulse (w_commit[gi])
        );
    end

    state_e            r_state_q, w_state_d;
    logic [VEC_W-1:0]  r_vec_q,   w_vec_d;
    logic [c_DW_W-1:0] r_dwell_q, w_dwell_d;
    logic              r_valid_q, w_valid_d;
    logic              r_busy_q,  w_busy_d;
    logic              r_done_q,  w_done_d;

    // vec_idx and {a,b,c} are always the same value, so one register holds both.
    always_comb begin
        w_state_d = r_state_q;
        w_vec_d   = r_vec_q;
        w_dwell_d = r_dwell_q;
        w_valid_d = 1'b0;
        w_busy_d  = r_busy_q;
        w_done_d  = 1'b0;
        case (r_state_q)
            IDLE: begin
                if (mode && start) begin
                    w_state_d = SWEEP;
                    w_vec_d   = '0;
                    w_dwell_d = '0;
                    w_valid_d = 1'b1;
                    w_busy_d  = 1'b1;
                end else if (!mode && (w_commit != '0)) begin
                    w_vec_d   = w_deb_val ^ w_commit;
                    w_valid_d = 1'b1;
                end
            end
            SWEEP: begin
                if (r_dwell_q == c_DWELL_LAST) begin
                    w_dwell_d = '0;
                    if (r_vec_q == c_VEC_LAST) begin
                        w_state_d = DONE;
                        w_busy_d  = 1'b0;
                        w_done_d  = 1'b1;
                    end else begin
                        w_vec_d   = r_vec_q + 1'b1;
                        w_valid_d = 1'b1;
                    end
                end else begin
                    w_dwell_d = r_dwell_q + 1'b1;
                end
            end
            DONE: begin
                w_state_d = IDLE;
            end
            default: begin
                w_state_d = IDLE;
                w_busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= IDLE;
            r_vec_q   <= '0;
            r_dwell_q <= '0;
            r_valid_q <= 1'b0;
            r_busy_q  <= 1'b0;
            r_done_q  <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_vec_q   <= w_vec_d;
            r_dwell_q <= w_dwell_d;
            r_valid_q <= w_valid_d;
            r_busy_q  <= w_busy_d;
            r_done_q  <= w_done_d;
        end
    end

    assign a         = r_vec_q[2];
    assign b         = r_vec_q[1];
    assign c         = r_vec_q[0];
    assign vec_idx   = r_vec_q;
    assign vec_valid = r_valid_q;
    assign busy      = r_busy_q;
    assign done      = r_done_q;

endmodule : gate_stimulus_sequencer
`default_nettype wire

// File: tb/tb_gate_stimulus_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_gate_stimulus_sequencer
// Brief   : Randomized bench for two sequencer instances (dwell 4 and dwell 1).
// Revision: 1.0 - initial release
// ============================================================================
module tb_gate_stimulus_sequencer;

    localparam int c_DEB = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       mode;
    logic       start;
    logic [2:0] sw;

    logic       a0, b0, c0, valid0, busy0, done0;
    logic [2:0] idx0;
    logic       a1, b1, c1, valid1, busy1, done1;
    logic [2:0] idx1;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    gate_stimulus_sequencer #(.DEBOUNCE_CYCLES(c_DEB), .DWELL_CYCLES(4)) u_dut0 (
        .clk(clk), .rst(rst), .mode(mode), .start(start), .sw(sw),
        .a(a0), .b(b0), .c(c0), .vec_valid(valid0), .vec_idx(idx0),
        .busy(busy0), .done(done0)
    );

    gate_stimulus_sequencer #(.DEBOUNCE_CYCLES(c_DEB), .DWELL_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst), .mode(mode), .start(start), .sw(sw),
        .a(a1), .b(b1), .c(c1), .vec_valid(valid1), .vec_idx(idx1),
        .busy(busy1), .done(done1)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: switch history window for debouncing, elapsed-time
    // arithmetic for the sweep (t = cycles since launch, -1 when not sweeping).
    logic [2:0] m_sync1, m_sync2, m_comm;
    logic [2:0] hist[$];
    int         m_t[2];
    int         m_dwell[2] = '{4, 1};
    logic [2:0] m_vec[2];
    logic       m_valid[2], m_busy[2], m_done[2];

    function automatic void derive(input int k);
        if (m_t[k] < 8 * m_dwell[k]) begin
            m_busy[k]  = 1'b1;
            m_done[k]  = 1'b0;
            m_vec[k]   = 3'(m_t[k] / m_dwell[k]);
            m_valid[k] = (m_t[k] % m_dwell[k]) == 0;
        end else begin
            m_busy[k]  = 1'b0;
            m_done[k]  = 1'b1;
            m_valid[k] = 1'b0;
            m_vec[k]   = 3'd7;
        end
    endfunction

    function automatic void model_step();
        logic [2:0] old_s2;
        logic [2:0] mask;
        logic       all_diff;
        if (rst) begin
            m_sync1 = '0; m_sync2 = '0; m_comm = '0;
            hist.delete();
            for (int k = 0; k < 2; k++) begin
                m_t[k] = -1; m_vec[k] = '0;
                m_valid[k] = 0; m_busy[k] = 0; m_done[k] = 0;
            end
            return;
        end
        old_s2  = m_sync2;
        m_sync2 = m_sync1;
        m_sync1 = sw;
        hist.push_back(old_s2);
        if (hist.size() > c_DEB) void'(hist.pop_front());
        mask = '0;
        if (hist.size() == c_DEB) begin
            for (int bt = 0; bt < 3; bt++) begin
                all_diff = 1'b1;
                for (int j = 0; j < c_DEB; j++)
                    if (hist[j][bt] == m_comm[bt]) all_diff = 1'b0;
                mask[bt] = all_diff;
            end
        end
        m_comm = m_comm ^ mask;
        for (int k = 0; k < 2; k++) begin
            if (m_t[k] >= 0) begin
                if (m_t[k] == 8 * m_dwell[k]) begin
                    m_t[k] = -1; m_done[k] = 0; m_valid[k] = 0;
                end else begin
                    m_t[k]++;
                    derive(k);
                end
            end else if (mode && start) begin
                m_t[k] = 0;
                derive(k);
            end else if (!mode && mask != 3'b000) begin
                m_vec[k] = m_comm; m_valid[k] = 1'b1;
            end else begin
                m_valid[k] = 1'b0;
            end
        end
    endfunction

    int busy_cnt0, done_cnt0, valid_cnt0;

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_step();
            #1;
            chk("abc0",   {5'b0, a0, b0, c0}, {5'b0, m_vec[0]});
            chk("idx0",   {5'b0, idx0},       {5'b0, m_vec[0]});
            chk("valid0", {7'b0, valid0},     {7'b0, m_valid[0]});
            chk("busy0",  {7'b0, busy0},      {7'b0, m_busy[0]});
            chk("done0",  {7'b0, done0},      {7'b0, m_done[0]});
            chk("abc1",   {5'b0, a1, b1, c1}, {5'b0, m_vec[1]});
            chk("idx1",   {5'b0, idx1},       {5'b0, m_vec[1]});
            chk("valid1", {7'b0, valid1},     {7'b0, m_valid[1]});
            chk("busy1",  {7'b0, busy1},      {7'b0, m_busy[1]});
            chk("done1",  {7'b0, done1},      {7'b0, m_done[1]});
            busy_cnt0  += int'(busy0);
            done_cnt0  += int'(done0);
            valid_cnt0 += int'(valid0);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int hold;
        int r;
        rst = 1'b1; mode = 1'b0; start = 1'b0; sw = 3'b000;
        cyc(3);
        rst = 1'b0;
        cyc(4);

        // Clean manual change, then explicit latency check.
        sw = 3'b101;
        valid_cnt0 = 0;
        cyc(9);
        chk("latency_pre", {5'b0, idx0}, 8'd0);
        cyc(1);
        chk("latency_10", {5'b0, idx0}, 8'd5);
        cyc(6);
        chk("manual_pulses", 8'(valid_cnt0), 8'd1);

        // Glitch on sw[1] shorter than the debounce window.
        valid_cnt0 = 0;
        sw = 3'b111; cyc(5);
        sw = 3'b101; cyc(15);
        chk("glitch_pulses", 8'(valid_cnt0), 8'd0);

        // Full sweep.
        mode = 1'b1; busy_cnt0 = 0; done_cnt0 = 0; valid_cnt0 = 0;
        start = 1'b1; cyc(1); start = 1'b0;
        cyc(40);
        chk("sweep_busy", 8'(busy_cnt0), 8'd32);
        chk("sweep_done", 8'(done_cnt0), 8'd1);
        chk("sweep_valid", 8'(valid_cnt0), 8'd8);

        // Interference during a sweep.
        busy_cnt0 = 0; valid_cnt0 = 0;
        start = 1'b1; cyc(1); start = 1'b0;
        cyc(8);
        mode = 1'b0; cyc(2);
        start = 1'b1; cyc(1); start = 1'b0;
        sw = 3'b010; cyc(14);
        mode = 1'b1; cyc(15);
        chk("intf_busy", 8'(busy_cnt0), 8'd32);
        chk("intf_valid", 8'(valid_cnt0), 8'd8);
        mode = 1'b0; cyc(5);

        // Back-to-back sweeps with start held.
        mode = 1'b1; start = 1'b1; cyc(40);
        start = 1'b0; cyc(40);

        // Reset mid-sweep.
        start = 1'b1; cyc(1); start = 1'b0;
        cyc(10);
        rst = 1'b1; cyc(1); rst = 1'b0;
        cyc(5);

        // Randomized traffic.
        hold = 0;
        for (int i = 0; i < 2000; i++) begin
            if (hold == 0) begin
                sw   = 3'($urandom_range(0, 7));
                hold = $urandom_range(1, 14);
            end
            hold--;
            r = $urandom_range(0, 99);
            if (r < 3) mode = ~mode;
            start = ($urandom_range(0, 19) == 0);
            rst   = ($urandom_range(0, 299) == 0);
            cyc(1);
        end
        rst = 1'b0; start = 1'b0;
        cyc(5);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_gate_stimulus_sequencer
`default_nettype wire
